prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the RV32I core's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into instruction memory through the memory's write-enable and data inputs. The core is held in reset until a complete frame with a correct checksum has been written.

---
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream (sync, length, data, checksum),
// writes assembled little-endian words into instruction memory and releases the core
// from reset once a frame with a matching checksum has been fully written.
module prog_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              core_rst_n_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int unsigned    CntW     = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [7:0]     SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle, StLen0, StLen1, StData, StCsum, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              rx_ready_q, core_rst_n_q, done_q, error_q;

  logic              accept;
  logic              timed_st;
  logic [15:0]       len_full;

  // Next-state: frame parsing, word assembly, checksum and idle timeout.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    wl_d       = wl_q;
    en_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    accept     = rx_valid_i & rx_ready_q;
    len_full   = {rx_data_i, len_lo_q};
    timed_st   = (state_q == StLen0) || (state_q == StLen1) ||
                 (state_q == StData) || (state_q == StCsum);

    if (!timed_st || accept) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      StIdle, StErr: begin
        if (accept && (rx_data_i == SyncByte)) state_d = StLen0;
      end
      StLen0: begin
        if (accept) begin
          len_lo_d = rx_data_i;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d      = len_full;
          wl_d       = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          if (32'(len_full) > MAX_WORDS) state_d = StErr;
          else if (len_full == 16'd0)    state_d = StCsum;
          else                           state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          // Shift in from the top so the first byte ends up in [7:0].
          word_d     = {rx_data_i, word_q[31:8]};
          csum_d     = csum_q ^ rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            en_d   = 1'b1;
            addr_d = wl_q[ADDR_W-1:0];
            data_d = word_d;
            wl_d   = wl_q + 1'b1;
            if (32'(wl_d) == 32'(len_q)) state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) state_d = (rx_data_i == csum_q) ? StDone : StErr;
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    // An accepted byte on the expiry edge keeps the frame alive.
    if (timed_st && !accept && (cnt_q == CntLast)) state_d = StErr;
  end

  // State and registered outputs; reset forces core reset and kills any pending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      wl_q         <= '0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rx_ready_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      wl_q         <= wl_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rx_ready_q   <= (state_d != StDone);
      core_rst_n_q <= (state_d == StDone);
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StErr);
    end
  end

  assign rx_ready_o     = rx_ready_q;
  assign imem_en_o      = en_q;
  assign imem_addr_o    = addr_q;
  assign imem_data_o    = data_q;
  assign core_rst_n_o   = core_rst_n_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with a short timeout.
module tb_prog_loader;

  localparam int unsigned AddrW      = 12;
  localparam int unsigned TimeoutCyc = 16;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready;
  logic             imem_en;
  logic [AddrW-1:0] imem_addr;
  logic [31:0]      imem_data;
  logic             core_rst_n;
  logic             done;
  logic             error;
  logic [AddrW:0]   words_loaded;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [AddrW-1:0] wr_addr_q[$];
  logic [31:0]      wr_data_q[$];

  byte_q_t frame_good;
  byte_q_t frame_bad;

  prog_loader #(
    .ADDR_W   (AddrW),
    .MAX_WORDS(4096),
    .TIMEOUT  (TimeoutCyc)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .rx_ready_o    (rx_ready),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_data_o   (imem_data),
    .core_rst_n_o  (core_rst_n),
    .done_o        (done),
    .error_o       (error),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  // Every cycle imem_en is high logs one write.
  always @(negedge clk) begin
    if (imem_en === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] addr,
                             input logic [31:0] data);
    if (wr_data_q.size() > idx) begin
      check_eq({tag, "_addr"}, 32'(wr_addr_q[idx]), addr);
      check_eq({tag, "_data"}, wr_data_q[idx], data);
    end else begin
      check_eq({tag, "_present"}, 32'(wr_data_q.size()), 32'(idx + 1));
    end
  endtask

  // Present one byte after `gap` idle edges; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      check_eq("rx_ready_stall", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t bytes, input int gap_max);
    foreach (bytes[i]) send_byte(bytes[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Data bytes 13 00 00 00 93 00 10 00 XOR to 0x90.
    frame_good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    frame_bad  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h91};

    // Reset values.
    #1 rst_n = 1'b0;
    #11;
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_imem_en", 32'(imem_en), 32'd0);
    check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_imem_data", imem_data, 32'd0);
    check_eq("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("ready_before_edge", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1 check_eq("ready_after_edge", 32'(rx_ready), 32'd1);

    // Normal load with leading junk; inspect write timing byte by byte.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    for (int i = 0; i < 7; i++) send_byte(frame_good[i], 0);
    check_eq("w0_en", 32'(imem_en), 32'd1);
    check_eq("w0_addr", 32'(imem_addr), 32'd0);
    check_eq("w0_data", imem_data, 32'h0000_0013);
    check_eq("w0_words", 32'(words_loaded), 32'd1);
    send_byte(frame_good[7], 0);
    check_eq("w0_en_one_cycle", 32'(imem_en), 32'd0);
    for (int i = 8; i < 11; i++) send_byte(frame_good[i], 0);
    check_eq("w1_en", 32'(imem_en), 32'd1);
    check_eq("w1_addr", 32'(imem_addr), 32'd1);
    check_eq("w1_data", imem_data, 32'h0010_0093);
    check_eq("w1_words", 32'(words_loaded), 32'd2);
    check_eq("pre_csum_done", 32'(done), 32'd0);
    send_byte(frame_good[11], 0);
    check_eq("ok_done", 32'(done), 32'd1);
    check_eq("ok_core_rst_n", 32'(core_rst_n), 32'd1);
    check_eq("ok_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("ok_error", 32'(error), 32'd0);
    idle_cycles(4);
    check_eq("ok_done_sticky", 32'(done), 32'd1);
    check_eq("ok_words", 32'(words_loaded), 32'd2);
    check_eq("ok_nwrites", 32'(wr_data_q.size()), 32'd2);

    // Bad checksum, then recovery with a good frame.
    apply_reset();
    send_frame(frame_bad, 0);
    check_eq("bad_error", 32'(error), 32'd1);
    check_eq("bad_done", 32'(done), 32'd0);
    check_eq("bad_core_rst_n", 32'(core_rst_n), 32'd0);
    check_eq("bad_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("bad_nwrites", 32'(wr_data_q.size()), 32'd2);
    send_byte(8'hA5, 0);
    check_eq("recover_error_clr", 32'(error), 32'd0);
    for (int i = 1; i < 12; i++) send_byte(frame_good[i], 0);
    check_eq("recover_done", 32'(done), 32'd1);
    check_eq("recover_nwrites", 32'(wr_data_q.size()), 32'd4);
    check_write("recover_w2", 2, 32'd0, 32'h0000_0013);
    check_write("recover_w3", 3, 32'd1, 32'h0010_0093);

    // Zero-length frame.
    apply_reset();
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
    check_eq("n0_done", 32'(done), 32'd1);
    check_eq("n0_nwrites", 32'(wr_data_q.size()), 32'd0);

    // Oversize and exactly-max lengths.
    apply_reset();
    send_frame('{8'hA5, 8'h01, 8'h10}, 0);
    check_eq("n4097_error", 32'(error), 32'd1);
    apply_reset();
    send_frame('{8'hA5, 8'h00, 8'h10}, 0);
    check_eq("n4096_no_error", 32'(error), 32'd0);

    // Timeout expires exactly TimeoutCyc edges after the last accept.
    apply_reset();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h13}, 0);
    idle_cycles(TimeoutCyc - 1);
    check_eq("to_not_yet", 32'(error), 32'd0);
    idle_cycles(1);
    check_eq("to_error", 32'(error), 32'd1);
    check_eq("to_nwrites", 32'(wr_data_q.size()), 32'd0);

    // A byte accepted on the expiry edge wins.
    apply_reset();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h13}, 0);
    send_byte(8'h00, TimeoutCyc - 1);
    check_eq("to_byte_wins", 32'(error), 32'd0);
    send_frame('{8'h00, 8'h00, 8'h13}, 0);
    check_eq("to_late_done", 32'(done), 32'd1);
    check_write("to_late_w0", 0, 32'd0, 32'h0000_0013);

    // Reset during a pending write pulse.
    apply_reset();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 0);
    check_eq("pend_en_high", 32'(imem_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("pend_en_killed", 32'(imem_en), 32'd0);
    check_eq("pend_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("pend_words", 32'(words_loaded), 32'd0);

    // Reset after two data bytes, then a full frame: no stale bytes merge in.
    apply_reset();
    send_frame('{8'hA5, 8'h02, 8'h00, 8'hEE, 8'hDD}, 0);
    apply_reset();
    send_frame(frame_good, 0);
    check_write("midrst_w0", 0, 32'd0, 32'h0000_0013);
    check_write("midrst_w1", 1, 32'd1, 32'h0010_0093);
    check_eq("midrst_done", 32'(done), 32'd1);

    // Throttled stream with junk ahead of the sync byte.
    apply_reset();
    send_frame('{8'h00, 8'hFF}, 3);
    send_frame(frame_good, TimeoutCyc - 4);
    check_eq("thr_nwrites", 32'(wr_data_q.size()), 32'd2);
    check_write("thr_w0", 0, 32'd0, 32'h0000_0013);
    check_write("thr_w1", 1, 32'd1, 32'h0010_0093);
    check_eq("thr_done", 32'(done), 32'd1);
    check_eq("thr_error", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
